// File: rtl/encoder_scan_pkg.sv
// Shared definitions for the sequential 16-to-4 encoder: widths, FSM encoding, helpers.
// Optional feature macro: ENC_ROUND_ROBIN_EN (round-robin start pointer).
package encoder_scan_pkg;

    localparam int N = 16;
    localparam int W = $clog2(N);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } enc_state_e;

    // True when exactly one bit of v is set.
    function automatic logic is_one_hot(input logic [N-1:0] v);
        return (v != '0) && ((v & (v - N'(1))) == '0);
    endfunction

endpackage

// File: rtl/encoder_scan_prio_sel.sv
// Combinational find-first-set over an N-bit request, searching upward from a start
// index and wrapping from N-1 to 0. Reports the winning index and whether any bit was set.
module enc_prio_sel
    import encoder_scan_pkg::*;
(
    input  logic [N-1:0] req,
    input  logic [W-1:0] start,
    output logic [W-1:0] sel,
    output logic         found
);

    // rot[k] is the request bit k places above start; N is a power of two so the add wraps.
    logic [N-1:0] rot;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_rot
            logic [W-1:0] src;
            assign src     = start + W'(gi);
            assign rot[gi] = req[src];
        end
    endgenerate

    // Scan from the far end so the nearest set bit is the last one written.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                sel   = start + W'(k);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/encoder_scan.sv
// Sequential 16-to-4 encoder: accepts a request vector and emits the index of each set bit,
// one per output beat. Define ENC_ROUND_ROBIN_EN for a persistent round-robin start pointer.
module encoder_scan
    import encoder_scan_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         ip_valid,
    output logic         ip_ready,
    input  logic [0:N-1] ip,
    output logic         op_valid,
    input  logic         op_ready,
    output logic [0:W-1] op,
    output logic         op_last,
    output logic         busy
);

    enc_state_e   state_reg, state_next;
    logic [N-1:0] pending_reg, pending_next;
    logic [N-1:0] ip_vec;
    logic [W-1:0] start;
    logic [W-1:0] sel;
    logic         found;
    logic         last;

    // Internal vectors are indexed by request number, independent of the port's bit order.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_ip
            assign ip_vec[gi] = ip[gi];
        end
    endgenerate

`ifdef ENC_ROUND_ROBIN_EN
    logic [W-1:0] pointer_reg, pointer_next;
    assign start = pointer_reg;
`else
    assign start = '0;
`endif

    enc_prio_sel u_sel (
        .req   (pending_reg),
        .start (start),
        .sel   (sel),
        .found (found)
    );

    assign last = is_one_hot(pending_reg);

    always_comb begin
        state_next   = state_reg;
        pending_next = pending_reg;
        ip_ready     = 1'b0;
        op_valid     = 1'b0;
        op           = '0;
        op_last      = 1'b0;
        busy         = 1'b0;
`ifdef ENC_ROUND_ROBIN_EN
        pointer_next = pointer_reg;
`endif
        case (state_reg)
            IDLE: begin
                // Held low while rst is asserted so nothing is handed over during reset.
                ip_ready = !rst;
                if (ip_valid && !rst && (ip_vec != '0)) begin
                    pending_next = ip_vec;
                    state_next   = SCAN;
                end
            end
            SCAN: begin
                busy     = 1'b1;
                op_valid = found;
                op       = sel;
                op_last  = found && last;
                if (found && op_ready) begin
                    pending_next[sel] = 1'b0;
`ifdef ENC_ROUND_ROBIN_EN
                    pointer_next = sel + W'(1);
`endif
                    if (last) begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            pending_reg <= '0;
`ifdef ENC_ROUND_ROBIN_EN
            pointer_reg <= '0;
`endif
        end else begin
            state_reg   <= state_next;
            pending_reg <= pending_next;
`ifdef ENC_ROUND_ROBIN_EN
            pointer_reg <= pointer_next;
`endif
        end
    end

endmodule

// File: tb/tb_encoder_scan.sv
// Scoreboard bench for encoder_scan: stimulus pushes expected beats from a behavioural
// model, a negedge monitor pops and compares whenever the DUT presents an index.
module tb_encoder_scan;

`ifdef ENC_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct packed {
        logic [3:0] idx;
        logic       last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        ip_valid;
    logic        ip_ready;
    logic [0:15] ip;
    logic        op_valid;
    logic        op_ready;
    logic [0:3]  op;
    logic        op_last;
    logic        busy;

    int   total = 0;
    int   bad   = 0;
    int   ptr_m = 0;
    int   rdy_mode = 0;
    exp_t        q[$];
    logic [0:15] vq[$];
    logic [0:15] dec_acc = '0;

    encoder_scan dut (
        .clk      (clk),
        .rst      (rst),
        .ip_valid (ip_valid),
        .ip_ready (ip_ready),
        .ip       (ip),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .op       (op),
        .op_last  (op_last),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", name, got, want, $time);
        end
    endtask

    // Reference: emit every set index in ascending order from the start point (0, or the
    // round-robin pointer), wrapping; the last emitted index carries op_last.
    task automatic model_push(input logic [0:15] v);
        int cnt = 0;
        int emitted = 0;
        int idx;
        for (int i = 0; i < 16; i++) if (v[i]) cnt++;
        if (cnt == 0) return;
        vq.push_back(v);
        for (int k = 0; k < 16; k++) begin
            idx = RR ? (ptr_m + k) % 16 : k;
            if (v[idx]) begin
                emitted++;
                q.push_back('{idx: 4'(idx), last: (emitted == cnt)});
                if (RR) ptr_m = (idx + 1) % 16;
            end
        end
    endtask

    // Monitor: every presented index must match the queue head; pop on handshake.
    always @(negedge clk) begin
        exp_t        e;
        logic [0:15] onehot;
        if (rst) begin
            dec_acc = '0;
        end else if (op_valid) begin
            if (q.size() == 0) begin
                check("stray_beat", {28'd0, op}, 32'hFFFF_FFFF);
            end else begin
                e = q[0];
                check("op_index", {28'd0, op}, {28'd0, e.idx});
                check("op_last", {31'd0, op_last}, {31'd0, e.last});
                if (op_ready) begin
                    void'(q.pop_front());
                    onehot = '0;
                    onehot[op] = 1'b1;
                    dec_acc = dec_acc | onehot;
                    if (op_last) begin
                        if (vq.size() == 0) check("loopback_vq", 32'd0, 32'd1);
                        else check("loopback", {16'd0, dec_acc}, {16'd0, vq.pop_front()});
                        dec_acc = '0;
                    end
                end
            end
        end
    end

    initial begin
        op_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       op_ready = 1'b1;
                1:       op_ready = 1'($urandom_range(0, 1));
                default: op_ready = 1'b0;
            endcase
        end
    end

    task automatic send(input logic [0:15] v);
        int n = 0;
        while (!ip_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!ip_ready) begin
            check("send_timeout", 32'd0, 32'd1);
            return;
        end
        ip       = v;
        ip_valid = 1'b1;
        model_push(v);
        @(posedge clk);
        #1;
        ip_valid = 1'b0;
        ip       = 16'($urandom);
        if (v != '0) begin
            check("accept_busy", {31'd0, busy}, 32'd1);
            check("accept_ready_low", {31'd0, ip_ready}, 32'd0);
            check("accept_latency", {31'd0, op_valid}, 32'd1);
        end else begin
            check("zero_ready", {31'd0, ip_ready}, 32'd1);
            check("zero_no_valid", {31'd0, op_valid}, 32'd0);
        end
        $display("vec %h issued, expected beats queued=%0d", v, q.size());
    endtask

    task automatic wait_drain();
        int n = 0;
        while (q.size() != 0 && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (q.size() != 0) check("drain_timeout", 32'(q.size()), 32'd0);
        check("turnaround_ready", {31'd0, ip_ready}, 32'd1);
        check("turnaround_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [0:15] v;
        rst      = 1'b1;
        ip_valid = 1'b0;
        ip       = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready_low", {31'd0, ip_ready}, 32'd0);
        check("rst_op_valid", {31'd0, op_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_op", {28'd0, op}, 32'd0);
        check("rst_op_last", {31'd0, op_last}, 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_ready", {31'd0, ip_ready}, 32'd1);

        // Round-robin ordering case (fixed build: ascending order).
        v = '0; v[3] = 1'b1;
        send(v); wait_drain();
        v = '0; v[1] = 1'b1; v[9] = 1'b1;
        send(v); wait_drain();

        // Basic: indices 2 and 15.
        v = 16'b0010_0000_0000_0001;
        send(v); wait_drain();

        // Backpressure: single index 7 held for 5 cycles.
        rdy_mode = 2;
        v = '0; v[7] = 1'b1;
        send(v);
        repeat (5) @(posedge clk);
        #1;
        check("bp_held_valid", {31'd0, op_valid}, 32'd1);
        check("bp_pending", 32'(q.size()), 32'd1);
        rdy_mode = 0;
        wait_drain();

        // Zero vector then full vector (16 back-to-back beats).
        send('0); wait_drain();
        send(16'hFFFF);
        repeat (16) @(posedge clk);
        #1;
        check("full_16_cycles", 32'(q.size()), 32'd0);
        check("full_ready", {31'd0, ip_ready}, 32'd1);

        // Loopback through a decoder model: every one-hot vector.
        for (int i = 0; i < 16; i++) begin
            v = '0; v[i] = 1'b1;
            send(v); wait_drain();
        end

        // Randomised vectors with random backpressure.
        rdy_mode = 1;
        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(0, 7))
                0:       v = '0;
                1:       begin v = '0; v[$urandom_range(0, 15)] = 1'b1; end
                default: v = 16'($urandom);
            endcase
            send(v); wait_drain();
        end
        rdy_mode = 0;

        // Reset mid-scan with all bits pending: nothing may follow.
        send(16'hFFFF);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        q.delete();
        vq.delete();
        ptr_m = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("midrst_op_valid", {31'd0, op_valid}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_ready", {31'd0, ip_ready}, 32'd1);
        repeat (20) @(posedge clk);
        #1;
        check("midrst_quiet", {31'd0, op_valid}, 32'd0);

        // Ordering after reset (round-robin pointer restarts at 0).
        v = '0; v[3] = 1'b1;
        send(v); wait_drain();
        v = '0; v[1] = 1'b1; v[9] = 1'b1;
        send(v); wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
